// File: rtl/cell_op_arbiter.sv
// cell_op_arbiter: shares one registered logic-cell evaluation unit between
// NREQ requesters. A three-state FSM (IDLE -> EVAL -> RESP) grants one
// requester per pass and returns a tagged result, so one op completes every
// three cycles.
//
// Build option: define CELL_OP_ARB_FIXED_PRIO_EN to select fixed priority
// (lowest asserted index wins, no rotating pointer). Left undefined, the
// arbiter is round-robin starting from the requester after the last winner.
// Timing, handshake and results are identical in both modes.
//
// Cycle view for a request sampled at rising edge k:
//   gnt[winner]      high during k..k+1
//   busy             high during k..k+2
//   res_valid/res_*  strobe during k+2..k+3
//   next arbitration at edge k+3

module cell_op_arbiter #(
    parameter int NREQ = 4,                         // number of requesters, 2..8
    parameter int IDW  = 2                          // ceil(log2(NREQ)), minimum 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   op,
    input  logic [NREQ-1:0]     a,
    input  logic [NREQ-1:0]     b,
    input  logic [NREQ-1:0]     sel,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic                res_data,
    output logic                res_err
);

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_BUF  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOT  = 3'd5,
        OP_MUX  = 3'd6,
        OP_RSVD = 3'd7
    } cell_op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q;

    // Operation latched at the grant edge; the requester may change its
    // inputs freely afterwards without disturbing the in-flight result.
    cell_op_e           op_q;
    logic               a_q;
    logic               b_q;
    logic               sel_q;
    logic [IDW-1:0]     idx_q;

    // Evaluation result captured in EVAL, published in RESP.
    logic               eval_data_q;
    logic               eval_err_q;

    // Registered outputs.
    logic [NREQ-1:0]    gnt_q;
    logic               res_valid_q;
    logic [IDW-1:0]     res_id_q;
    logic               res_data_q;
    logic               res_err_q;

`ifndef CELL_OP_ARB_FIXED_PRIO_EN
    // Index scanned first at the next arbitration.
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     rr_ptr_d;
`endif

    // Combinational arbitration and evaluation results.
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic               eval_data_d;
    logic               eval_err_d;

    // ------------------------------------------------------------------
    // Winner selection among the currently asserted requests.
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef CELL_OP_ARB_FIXED_PRIO_EN
        // Descending scan: the last hit, i.e. the lowest index, wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
`else
        // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[(int'(rr_ptr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
`endif
    end

`ifndef CELL_OP_ARB_FIXED_PRIO_EN
    // Pointer moves to the requester after the winner, wrapping NREQ-1 -> 0.
    always_comb begin
        rr_ptr_d = IDW'((int'(win_idx) + 1) % NREQ);
    end
`endif

    // ------------------------------------------------------------------
    // Cell function of the latched operation.
    // ------------------------------------------------------------------
    always_comb begin
        eval_data_d = 1'b0;
        eval_err_d  = 1'b0;
        unique case (op_q)
            OP_BUF:  eval_data_d = a_q;
            OP_AND:  eval_data_d = a_q & b_q;
            OP_OR:   eval_data_d = a_q | b_q;
            OP_XOR:  eval_data_d = a_q ^ b_q;
            OP_NAND: eval_data_d = ~(a_q & b_q);
            OP_NOT:  eval_data_d = ~a_q;
            OP_MUX:  eval_data_d = sel_q ? b_q : a_q;
            OP_RSVD: eval_err_d  = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs: grant in IDLE, evaluate in EVAL,
    // publish the tagged result when leaving RESP.
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register samples pre-edge values regardless of statement order.
    // NOTE: the small latched-operand registers are reset too, so the unit
    // comes out of reset in a fully defined state; reset discards any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_BUF;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            sel_q       <= 1'b0;
            idx_q       <= '0;
            eval_data_q <= 1'b0;
            eval_err_q  <= 1'b0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= 1'b0;
            res_err_q   <= 1'b0;
`ifndef CELL_OP_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Result strobes last exactly one cycle.
                    res_valid_q <= 1'b0;
                    res_err_q   <= 1'b0;
                    if (win_found) begin
                        op_q    <= cell_op_e'(op[3*int'(win_idx) +: 3]);
                        a_q     <= a[win_idx];
                        b_q     <= b[win_idx];
                        sel_q   <= sel[win_idx];
                        idx_q   <= win_idx;
                        gnt_q   <= NREQ'(1) << win_idx;
`ifndef CELL_OP_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= rr_ptr_d;
`endif
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    gnt_q       <= '0;
                    eval_data_q <= eval_data_d;
                    eval_err_q  <= eval_err_d;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    // res_id/res_data hold until the next result is published.
                    res_valid_q <= 1'b1;
                    res_id_q    <= idx_q;
                    res_data_q  <= eval_data_q;
                    res_err_q   <= eval_err_q;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule
